// File: rtl/data_memory.sv
// MIPS data-memory stage: byte/halfword/word loads and stores with a configurable load latency.
// Optional trace output is enabled by defining DMEM_TRACE_EN.
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] lat_idx;
    logic [1:0]    lat_off;
    logic [1:0]    lat_size;
    logic          lat_sext;

    logic is_idle, bad_size, bad_align, bad_range, faulty;
    logic accept_rd, accept_wr, reject, finish_load;
    logic [AW-1:0] widx, src_idx;
    logic [1:0]    src_off, src_size;
    logic          src_sext;
    logic [3:0]    be;
    logic [31:0]   wlane, load_val;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   extract = sx ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   extract = sx ? {{16{h[15]}}, h} : {16'h0, h};
            default: extract = w;
        endcase
    endfunction

    // Request qualification; only meaningful while IDLE.
    always_comb begin
        is_idle   = (state == IDLE);
        bad_size  = (size == 2'b11);
        bad_align = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
        bad_range = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
        faulty    = (mem_read && mem_write) || bad_size || bad_align || bad_range;
        accept_rd = is_idle && mem_read && !faulty;
        accept_wr = is_idle && mem_write && !faulty;
        reject    = is_idle && (mem_read || mem_write) && faulty;
        widx      = addr[AW+1:2];
    end

    // A zero-latency load completes straight from the live inputs; otherwise use the latched copy.
    always_comb begin
        src_idx  = is_idle ? widx     : lat_idx;
        src_off  = is_idle ? addr[1:0] : lat_off;
        src_size = is_idle ? size     : lat_size;
        src_sext = is_idle ? sign_ext : lat_sext;
        load_val = extract(mem[src_idx], src_off, src_size, src_sext);
        finish_load = (accept_rd && (LATENCY == 0)) || ((state == WAIT) && (cnt <= 3'd1));
    end

    always_comb begin
        be    = 4'b0000;
        wlane = wdata;
        case (size)
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wlane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept_rd) begin
                    cnt_nxt   = 3'(LATENCY);
                    state_nxt = (LATENCY == 0) ? DONE : WAIT;
                end else if (accept_wr) begin
                    state_nxt = DONE;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt <= 3'd1) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = accept_rd || (state == WAIT);
        done      = (state == DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
            rdata <= 32'h0;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            fault <= reject;
            if (reject) rdata <= 32'h0;
            else if (finish_load) rdata <= load_val;
            if (accept_rd) begin
                lat_idx  <= widx;
                lat_off  <= addr[1:0];
                lat_size <= size;
                lat_sext <= sign_ext;
            end
        end
    end

    // The array is deliberately outside reset so committed stores survive it.
    always_ff @(posedge clk) begin
        if (!reset && accept_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[widx][8*k +: 8] <= wlane[8*k +: 8];
            end
        end
    end

`ifdef DMEM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (accept_wr)
                $display("** %s %h %h", (size == 2'b00) ? "sb" : (size == 2'b01) ? "sh" : "sw",
                         addr, wdata);
            if (finish_load)
                $display("** %s %h %h", (src_size == 2'b00) ? "lb" : (src_size == 2'b01) ? "lh" : "lw",
                         {{(30-AW){1'b0}}, src_idx, src_off}, load_val);
            if (reject)
                $display("** dmem fault %h", addr);
        end
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: one instance at LATENCY=1, one at LATENCY=3.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst_s   [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic [1:0]  size_s  [2];
    logic        sx_s    [2];
    logic [31:0] rdata_s [2];
    logic        done_s  [2];
    logic        busy_s  [2];
    logic        fault_s [2];
    logic [1:0]  st_s    [2];

    // Entry layout: {fault, done, rdata}
    logic [33:0] exp_q0[$];
    logic [33:0] exp_q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_memory #(.DEPTH_WORDS(256), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(rst_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
        .mem_read(rd_s[0]), .mem_write(wr_s[0]), .size(size_s[0]), .sign_ext(sx_s[0]),
        .rdata(rdata_s[0]), .done(done_s[0]), .busy(busy_s[0]), .fault(fault_s[0]),
        .dbg_state(st_s[0])
    );

    data_memory #(.DEPTH_WORDS(256), .LATENCY(3)) u_lat3 (
        .clk(clk), .reset(rst_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
        .mem_read(rd_s[1]), .mem_write(wr_s[1]), .size(size_s[1]), .sign_ext(sx_s[1]),
        .rdata(rdata_s[1]), .done(done_s[1]), .busy(busy_s[1]), .fault(fault_s[1]),
        .dbg_state(st_s[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_out(input int u);
        logic [33:0] e;
        logic        have;
        have = 1'b0;
        e    = '0;
        if (u == 0) begin
            if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
        end else begin
            if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
        end
        if (!have) begin
            n_checks++;
            n_fail++;
            $display("FAIL u%0d_unexpected_out actual=done%0b/fault%0b rdata=%h required=no output",
                     u, done_s[u], fault_s[u], rdata_s[u]);
        end else begin
            check($sformatf("u%0d_fault", u), {31'h0, fault_s[u]}, {31'h0, e[33]});
            check($sformatf("u%0d_done", u), {31'h0, done_s[u]}, {31'h0, e[32]});
            check($sformatf("u%0d_rdata", u), rdata_s[u], e[31:0]);
        end
    endtask

    // Monitor: pops an expectation whenever a unit reports completion or rejection.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (done_s[u] || fault_s[u]) check_out(u);
        end
    end

    task automatic access(input int u, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                          input logic is_fault, input logic [31:0] exp_rd,
                          input int exp_lat, input int exp_busy);
        int   cyc;
        int   busy_cnt;
        logic got;
        @(negedge clk);
        addr_s[u]  = a;
        wdata_s[u] = wd;
        rd_s[u]    = rd;
        wr_s[u]    = wr;
        size_s[u]  = sz;
        sx_s[u]    = sx;
        if (u == 0) exp_q0.push_back({is_fault, !is_fault, exp_rd});
        else        exp_q1.push_back({is_fault, !is_fault, exp_rd});
        #1;
        busy_cnt = busy_s[u] ? 1 : 0;
        @(posedge clk);
        #1;
        rd_s[u] = 1'b0;
        wr_s[u] = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done_s[u] || fault_s[u]) got = 1'b1;
            else if (busy_s[u]) busy_cnt++;
        end
        check($sformatf("u%0d_completed@%h", u, a), {31'h0, got}, 32'h1);
        check($sformatf("u%0d_latency@%h", u, a), 32'(cyc), 32'(exp_lat));
        check($sformatf("u%0d_busy_cycles@%h", u, a), 32'(busy_cnt), 32'(exp_busy));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b1; addr_s[u] = '0; wdata_s[u] = '0; rd_s[u] = 1'b0;
            wr_s[u] = 1'b0; size_s[u] = 2'b10; sx_s[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d_reset_rdata", u), rdata_s[u], 32'h0);
            check($sformatf("u%0d_reset_done", u), {31'h0, done_s[u]}, 32'h0);
            check($sformatf("u%0d_reset_fault", u), {31'h0, fault_s[u]}, 32'h0);
            check($sformatf("u%0d_reset_busy", u), {31'h0, busy_s[u]}, 32'h0);
            check($sformatf("u%0d_reset_state", u), {30'h0, st_s[u]}, 32'h0);
        end
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;

        // LATENCY=1: loads finish 2 cycles after sampling with busy high for 2 cycles.
        access(0, 0, 1, 32'h10,  32'hDEADBEEF, 2'b10, 0, 0, 32'h00000000, 1, 0);
        access(0, 1, 0, 32'h10,  32'h0,        2'b10, 0, 0, 32'hDEADBEEF, 2, 2);
        access(0, 1, 0, 32'h13,  32'h0,        2'b00, 1, 0, 32'hFFFFFFDE, 2, 2);
        access(0, 1, 0, 32'h10,  32'h0,        2'b01, 0, 0, 32'h0000BEEF, 2, 2);
        access(0, 0, 1, 32'h11,  32'hAAAAAA55, 2'b00, 0, 0, 32'h0000BEEF, 1, 0);
        access(0, 1, 0, 32'h10,  32'h0,        2'b10, 0, 0, 32'hDEAD55EF, 2, 2);
        access(0, 1, 0, 32'h11,  32'h0,        2'b01, 0, 1, 32'h00000000, 1, 0);
        access(0, 1, 0, 32'h400, 32'h0,        2'b10, 0, 1, 32'h00000000, 1, 0);
        access(0, 1, 0, 32'h10,  32'h0,        2'b10, 0, 0, 32'hDEAD55EF, 2, 2);
        access(0, 1, 1, 32'h10,  32'h0,        2'b10, 0, 1, 32'h00000000, 1, 0);
        access(0, 1, 0, 32'h10,  32'h0,        2'b10, 0, 0, 32'hDEAD55EF, 2, 2);
        access(0, 1, 0, 32'h10,  32'h0,        2'b11, 0, 1, 32'h00000000, 1, 0);
        access(0, 0, 1, 32'h12,  32'h11111111, 2'b10, 0, 1, 32'h00000000, 1, 0);
        access(0, 1, 0, 32'h10,  32'h0,        2'b10, 0, 0, 32'hDEAD55EF, 2, 2);
        access(0, 0, 1, 32'h12,  32'h00008001, 2'b01, 0, 0, 32'hDEAD55EF, 1, 0);
        access(0, 1, 0, 32'h10,  32'h0,        2'b10, 0, 0, 32'h800155EF, 2, 2);
        access(0, 1, 0, 32'h12,  32'h0,        2'b01, 1, 0, 32'hFFFF8001, 2, 2);
        access(0, 0, 1, 32'h16,  32'h1234CAFE, 2'b01, 0, 0, 32'hFFFF8001, 1, 0);
        access(0, 1, 0, 32'h16,  32'h0,        2'b01, 1, 0, 32'hFFFFCAFE, 2, 2);
        access(0, 1, 0, 32'h17,  32'h0,        2'b00, 0, 0, 32'h000000CA, 2, 2);
        access(0, 1, 0, 32'h16,  32'h0,        2'b00, 1, 0, 32'hFFFFFFFE, 2, 2);
        access(0, 0, 1, 32'h3FC, 32'h01234567, 2'b10, 0, 0, 32'hFFFFFFFE, 1, 0);
        access(0, 1, 0, 32'h3FC, 32'h0,        2'b10, 0, 0, 32'h01234567, 2, 2);
        access(0, 1, 0, 32'h3FD, 32'h0,        2'b00, 1, 0, 32'h00000045, 2, 2);

        // LATENCY=3: a load aborted by reset in its second WAIT cycle.
        access(1, 0, 1, 32'h20, 32'hA5A5A5A5, 2'b10, 0, 0, 32'h00000000, 1, 0);
        access(1, 1, 0, 32'h20, 32'h0,        2'b10, 0, 0, 32'hA5A5A5A5, 4, 4);
        @(negedge clk);
        addr_s[1] = 32'h20; size_s[1] = 2'b10; rd_s[1] = 1'b1;
        @(posedge clk);
        #1;
        rd_s[1] = 1'b0;
        @(negedge clk);
        check("u1_first_wait_state", {30'h0, st_s[1]}, 32'h1);
        @(negedge clk);
        check("u1_second_wait_busy", {31'h0, busy_s[1]}, 32'h1);
        rst_s[1] = 1'b1;
        @(negedge clk);
        check("u1_abort_rdata", rdata_s[1], 32'h0);
        check("u1_abort_done", {31'h0, done_s[1]}, 32'h0);
        check("u1_abort_busy", {31'h0, busy_s[1]}, 32'h0);
        check("u1_abort_fault", {31'h0, fault_s[1]}, 32'h0);
        check("u1_abort_state", {30'h0, st_s[1]}, 32'h0);
        rst_s[1] = 1'b0;
        repeat (6) @(negedge clk);
        access(1, 1, 0, 32'h20, 32'h0, 2'b10, 0, 0, 32'hA5A5A5A5, 4, 4);
        access(1, 1, 0, 32'h22, 32'h0, 2'b01, 1, 0, 32'hFFFFA5A5, 4, 4);

        repeat (3) @(negedge clk);
        check("queues_drained", 32'(exp_q0.size() + exp_q1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
